// File: rtl/cache_req_arbiter.sv
// rtl/cache_req_arbiter.sv - round-robin arbiter sharing one cache port between NREQ requesters
//
// Accepts one request at a time from NREQ requesters (round-robin from rr_ptr),
// issues it to the cache, waits for the response and routes rdata/hit back to the
// owning requester as a one-cycle pulse. Single outstanding transaction.
//
// Optional feature macro: CACHE_ARB_STATS_EN
//   defined     -> per-requester saturating grant counters and a saturating hit counter
//   not defined -> stat_grants_o / stat_hits_o tied to 0, stat_clr_i unused
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_valid_i/req_ready_o   per-requester request / one-hot accept pulse
//   req_we_i/addr_i/wdata_i   per-requester payload, requester i at slice i
//   rsp_valid_o               one-hot, one-cycle response pulse to the owner
//   rsp_rdata_o/rsp_hit_o     response data and hit flag
//   c_req_valid_o/c_req_ready_i, c_we_o/c_addr_o/c_wdata_o   cache request side
//   c_rsp_valid_i/c_rsp_rdata_i/c_rsp_hit_i                  cache response side
//   stat_clr_i, stat_grants_o, stat_hits_o                   statistics

module cache_req_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int STAT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [NREQ-1:0]          req_we_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ*DATA_W-1:0]   req_wdata_i,
    output logic [NREQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_rdata_o,
    output logic                     rsp_hit_o,
    output logic                     c_req_valid_o,
    input  logic                     c_req_ready_i,
    output logic                     c_we_o,
    output logic [ADDR_W-1:0]        c_addr_o,
    output logic [DATA_W-1:0]        c_wdata_o,
    input  logic                     c_rsp_valid_i,
    input  logic [DATA_W-1:0]        c_rsp_rdata_i,
    input  logic                     c_rsp_hit_i,
    input  logic                     stat_clr_i,
    output logic [NREQ*STAT_W-1:0]   stat_grants_o,
    output logic [STAT_W-1:0]        stat_hits_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              c_we_q, c_we_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [DATA_W-1:0] c_wdata_q, c_wdata_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_hit_q, rsp_hit_d;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rsp_fire;

    // Round-robin pick: first pending requester scanning upward from rr_ptr, wrapping.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && req_valid_i[IW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    // Payload mux for the winner, using constant slices only.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IW'(k)) begin
                sel_we    = req_we_i[k];
                sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Accept pulse is combinational; suppressed while reset is asserted so that no
    // requester believes it was accepted in a cycle whose state update is discarded.
    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_IDLE && win_found && !reset_i) begin
            req_ready_o = NREQ'(1) << win_idx;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        c_we_d      = c_we_q;
        c_addr_d    = c_addr_q;
        c_wdata_d   = c_wdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_fire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // c_rsp_valid_i is deliberately ignored here.
                if (win_found) begin
                    owner_d   = win_idx;
                    c_we_d    = sel_we;
                    c_addr_d  = sel_addr;
                    c_wdata_d = sel_wdata;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (c_req_ready_i) begin
                    // A response arriving with the handshake completes the transaction.
                    if (c_rsp_valid_i) begin
                        rsp_fire = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (c_rsp_valid_i) begin
                    rsp_fire = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rsp_fire) begin
            rsp_valid_d = NREQ'(1) << owner_q;
            rsp_rdata_d = c_rsp_rdata_i;
            rsp_hit_d   = c_rsp_hit_i;
            rr_ptr_d    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            c_we_q      <= 1'b0;
            c_addr_q    <= '0;
            c_wdata_q   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            c_we_q      <= c_we_d;
            c_addr_q    <= c_addr_d;
            c_wdata_q   <= c_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_hit_q   <= rsp_hit_d;
        end
    end

    assign c_req_valid_o = (state_q == ST_ISSUE);
    assign c_we_o        = c_we_q;
    assign c_addr_o      = c_addr_q;
    assign c_wdata_o     = c_wdata_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_hit_o     = rsp_hit_q;

`ifdef CACHE_ARB_STATS_EN
    logic [STAT_W-1:0] grants_q [NREQ];
    logic [STAT_W-1:0] hits_q;

    // Saturating counters; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (reset_i || stat_clr_i) begin
            for (int k = 0; k < NREQ; k++) begin
                grants_q[k] <= '0;
            end
            hits_q <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (req_ready_o[k] && grants_q[k] != '1) begin
                    grants_q[k] <= grants_q[k] + 1'b1;
                end
            end
            if (rsp_fire && c_rsp_hit_i && hits_q != '1) begin
                hits_q <= hits_q + 1'b1;
            end
        end
    end

    always_comb begin
        stat_grants_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            stat_grants_o[k*STAT_W +: STAT_W] = grants_q[k];
        end
    end

    assign stat_hits_o = hits_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr_i;
    assign stat_grants_o   = '0;
    assign stat_hits_o     = '0;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb/tb_cache_req_arbiter.sv - randomized self-checking bench for cache_req_arbiter
module tb_cache_req_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int SW   = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_ready, req_we, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_hit;
    logic              c_req_valid, c_req_ready, c_we;
    logic [AW-1:0]     c_addr;
    logic [DW-1:0]     c_wdata;
    logic              c_rsp_valid;
    logic [DW-1:0]     c_rsp_rdata;
    logic              c_rsp_hit;
    logic              stat_clr;
    logic [NREQ*SW-1:0] stat_grants;
    logic [SW-1:0]     stat_hits;

    always #5 clk = ~clk;

    cache_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .STAT_W(SW)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_hit_o(rsp_hit),
        .c_req_valid_o(c_req_valid), .c_req_ready_i(c_req_ready), .c_we_o(c_we),
        .c_addr_o(c_addr), .c_wdata_o(c_wdata),
        .c_rsp_valid_i(c_rsp_valid), .c_rsp_rdata_i(c_rsp_rdata), .c_rsp_hit_i(c_rsp_hit),
        .stat_clr_i(stat_clr), .stat_grants_o(stat_grants), .stat_hits_o(stat_hits)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Transaction-level model: pending requests, one outstanding transaction,
    // a round-robin pointer and the response expected on the next cycle.
    bit            pend [NREQ];
    logic          p_we [NREQ];
    logic [AW-1:0] p_addr [NREQ];
    logic [DW-1:0] p_wdata [NREQ];
    int            rr;
    bit            busy, issued;
    int            own;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    bit            exp_rsp;
    int            exp_own;
    logic [DW-1:0] exp_rdata;
    logic          exp_hit;
    int            m_grants [NREQ];
    int            m_hits;

    task automatic respond();
        exp_rsp   = 1'b1;
        exp_own   = own;
        exp_rdata = c_rsp_rdata;
        exp_hit   = c_rsp_hit;
        busy      = 1'b0;
        issued    = 1'b0;
        rr        = (own + 1) % NREQ;
        if (c_rsp_hit && m_hits < SMAX) m_hits++;
    endtask

    task automatic check_stats();
        for (int i = 0; i < NREQ; i++) begin
`ifdef CACHE_ARB_STATS_EN
            check("stat_grants", 32'(stat_grants[i*SW +: SW]), 32'(m_grants[i]));
`else
            check("stat_grants", 32'(stat_grants[i*SW +: SW]), 32'd0);
`endif
        end
`ifdef CACHE_ARB_STATS_EN
        check("stat_hits", 32'(stat_hits), 32'(m_hits));
`else
        check("stat_hits", 32'(stat_hits), 32'd0);
`endif
    endtask

    initial begin
        int w;
        bit rst;
        logic [NREQ-1:0] exp_ready, exp_rv;

        // Reset held two cycles with both requesters asking.
        reset       = 1'b1;
        req_valid   = '1;
        req_we      = '1;
        req_addr    = '1;
        req_wdata   = '1;
        c_req_ready = 1'b1;
        c_rsp_valid = 1'b1;
        c_rsp_rdata = '1;
        c_rsp_hit   = 1'b1;
        stat_clr    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_c_req_valid", 32'(c_req_valid), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_hit", 32'(rsp_hit), 32'd0);
        check("rst_c_we", 32'(c_we), 32'd0);
        check("rst_c_addr", 32'(c_addr), 32'd0);
        check("rst_c_wdata", 32'(c_wdata), 32'd0);
        check("rst_stat_grants", 32'(stat_grants), 32'd0);
        check("rst_stat_hits", 32'(stat_hits), 32'd0);

        rr = 0; busy = 0; issued = 0; own = 0; exp_rsp = 0; m_hits = 0;
        exp_own = 0; exp_rdata = '0; exp_hit = 1'b0;
        cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; m_grants[i] = 0;
            p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
        end

        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc > 0) @(negedge clk);
            rst = (cyc < 20) ? 1'b0 : ($urandom_range(0, 99) < 2);
            reset = rst;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i]    = 1'b1;
                    p_we[i]    = 1'($urandom);
                    p_addr[i]  = AW'($urandom);
                    p_wdata[i] = DW'($urandom);
                end
                req_valid[i]           = pend[i];
                req_we[i]              = pend[i] ? p_we[i] : 1'($urandom);
                req_addr[i*AW +: AW]   = pend[i] ? p_addr[i] : AW'($urandom);
                req_wdata[i*DW +: DW]  = pend[i] ? p_wdata[i] : DW'($urandom);
            end
            c_req_ready = ($urandom_range(0, 99) < 50);
            if (busy && issued)
                c_rsp_valid = ($urandom_range(0, 99) < 35);
            else if (busy && c_req_ready)
                c_rsp_valid = ($urandom_range(0, 99) < 25);
            else if (!busy)
                c_rsp_valid = ($urandom_range(0, 99) < 10);
            else
                c_rsp_valid = 1'b0;
            c_rsp_rdata = DW'($urandom);
            c_rsp_hit   = 1'($urandom);
            stat_clr    = ($urandom_range(0, 99) < 4);
            #1;

            w = -1;
            if (!rst && !busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && pend[(rr + k) % NREQ]) w = (rr + k) % NREQ;
                end
            end
            exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_ready));

            if (!rst) begin
                check("c_req_valid", 32'(c_req_valid), 32'(busy && !issued));
                if (busy && !issued) begin
                    check("c_we", 32'(c_we), 32'(cur_we));
                    check("c_addr", 32'(c_addr), 32'(cur_addr));
                    check("c_wdata", 32'(c_wdata), 32'(cur_wdata));
                end
                exp_rv = exp_rsp ? (NREQ'(1) << exp_own) : '0;
                check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
                if (exp_rsp) begin
                    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                    check("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
                end
            end
            check_stats();

            // Advance the model across the coming rising edge.
            exp_rsp = 1'b0;
            if (rst) begin
                busy = 0; issued = 0; rr = 0; own = 0; m_hits = 0;
                for (int i = 0; i < NREQ; i++) m_grants[i] = 0;
            end else begin
                if (w >= 0) begin
                    busy      = 1'b1;
                    issued    = 1'b0;
                    own       = w;
                    cur_we    = p_we[w];
                    cur_addr  = p_addr[w];
                    cur_wdata = p_wdata[w];
                    pend[w]   = 1'b0;
                    if (m_grants[w] < SMAX) m_grants[w]++;
                end else if (busy && !issued && c_req_ready) begin
                    if (c_rsp_valid) respond();
                    else issued = 1'b1;
                end else if (busy && issued && c_rsp_valid) begin
                    respond();
                end
                if (stat_clr) begin
                    m_hits = 0;
                    for (int i = 0; i < NREQ; i++) m_grants[i] = 0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
